// File: rtl/adc_capture_driver.sv
// Triggered ADC burst capture into block RAM, then AXIS readout toward the PS.
// Single pl_clk domain; RAM is not reset, control state is.
module adc_capture_driver #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 10
) (
   input  logic              pl_clk,
   input  logic              rst,
   input  logic              arm,
   input  logic              abort,
   input  logic              trigger,
   input  logic [ADDR_W:0]   capture_len,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,
   output logic              m_axis_tlast,
   output logic              armed,
   output logic              busy,
   output logic              done,
   output logic              len_err
);

   localparam int unsigned     DEPTH   = 1 << ADDR_W;
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE_L   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] ONE_A = (ADDR_W)'(1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ARMED = 2'd1;
   localparam logic [1:0] S_CAPT  = 2'd2;
   localparam logic [1:0] S_READ  = 2'd3;

   logic [1:0]        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   rd_cnt_q, rd_cnt_d;
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic              trig_q;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              infl_q, infl_last_q;
   logic [DATA_W-1:0] dat_q [2];
   logic [1:0]        lst_q;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] rd_data_q;

   logic            len_ok, fire, wr_en, wr_last;
   logic            rd_en, pop, fin, flush, push_idx;
   logic [ADDR_W:0] len_m1;
   logic [2:0]      occ;

   assign len_m1  = len_q - ONE_L;
   assign len_ok  = (capture_len != '0) && (capture_len <= DEPTH_L);
   assign fire    = trigger & ~trig_q;
   assign wr_en   = (state_q == S_CAPT) & s_axis_tvalid;
   assign wr_last = wr_en & ({1'b0, wr_ptr_q} == len_m1);
   assign pop     = m_axis_tvalid & m_axis_tready;
   assign fin     = pop & lst_q[0];
   assign flush   = abort | fin;

   // Reads in flight plus skid entries never exceed the 2-entry skid.
   assign occ   = {1'b0, cnt_q} + {2'b00, infl_q} - {2'b00, pop};
   assign rd_en = (state_q == S_READ) & (rd_cnt_q != len_q)
                & (occ <= 3'd1) & ~abort;
   assign push_idx = (cnt_q == 2'd2) | ((cnt_q == 2'd1) & ~pop);

   always_comb begin
      state_d  = state_q;
      len_d    = len_q;
      wr_ptr_d = wr_ptr_q;
      rd_cnt_d = rd_cnt_q;
      done_d   = done_q;
      err_d    = err_q;
      if (abort) begin
         state_d = S_IDLE;
         done_d  = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (arm) begin
                  done_d = 1'b0;
                  if (len_ok) begin
                     len_d    = capture_len;
                     wr_ptr_d = '0;
                     rd_cnt_d = '0;
                     err_d    = 1'b0;
                     state_d  = S_ARMED;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_ARMED: if (fire) state_d = S_CAPT;
            S_CAPT: begin
               if (wr_en) begin
                  wr_ptr_d = wr_ptr_q + ONE_A;
                  if (wr_last) state_d = S_READ;
               end
            end
            S_READ: begin
               if (rd_en) rd_cnt_d = rd_cnt_q + ONE_L;
               if (fin) begin
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (flush) cnt_d = '0;
      else       cnt_d = cnt_q + {1'b0, infl_q} - {1'b0, pop};
   end

   always_ff @(posedge pl_clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         wr_ptr_q    <= '0;
         rd_cnt_q    <= '0;
         trig_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         cnt_q       <= '0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
         dat_q[0]    <= '0;
         dat_q[1]    <= '0;
         lst_q       <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_cnt_q    <= rd_cnt_d;
         trig_q      <= trigger;
         done_q      <= done_d;
         err_q       <= err_d;
         cnt_q       <= cnt_d;
         infl_q      <= rd_en;
         infl_last_q <= rd_en & (rd_cnt_q == len_m1);
         if (pop) begin
            dat_q[0] <= dat_q[1];
            lst_q[0] <= lst_q[1];
         end
         if (infl_q & ~flush) begin
            dat_q[push_idx] <= rd_data_q;
            lst_q[push_idx] <= infl_last_q;
         end
      end
   end

   always_ff @(posedge pl_clk) begin
      if (wr_en) mem[wr_ptr_q] <= s_axis_tdata;
      if (rd_en) rd_data_q <= mem[rd_cnt_q[ADDR_W-1:0]];
   end

   assign s_axis_tready = 1'b1;
   assign m_axis_tvalid = (cnt_q != 2'd0);
   assign m_axis_tdata  = dat_q[0];
   assign m_axis_tlast  = m_axis_tvalid & lst_q[0];
   assign armed         = (state_q == S_ARMED);
   assign busy          = (state_q != S_IDLE);
   assign done          = done_q;
   assign len_err       = err_q;

endmodule

// File: tb/tb_adc_capture_driver.sv
// Bench for adc_capture_driver: queue model of captured beats, per-cycle
// readout compare, and directed burst/abort/reset scenarios.
module tb_adc_capture_driver;

   localparam int DW    = 256;
   localparam int AW    = 10;
   localparam int DEPTH = 1024;

   logic          pl_clk = 1'b0;
   logic          rst = 1'b1;
   logic          arm = 1'b0;
   logic          abort = 1'b0;
   logic          trigger = 1'b0;
   logic [AW:0]   capture_len = '0;
   logic [DW-1:0] s_axis_tdata = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tvalid;
   logic          m_axis_tready = 1'b1;
   logic          m_axis_tlast;
   logic          armed, busy, done, len_err;

   int checks = 0;
   int errors = 0;
   int hs = 0;
   int cap_len = 0;
   int cap_n = 0;
   bit drop_ok = 1'b0;
   logic [DW-1:0] exp_q[$];

   adc_capture_driver #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .pl_clk(pl_clk), .rst(rst), .arm(arm), .abort(abort),
      .trigger(trigger), .capture_len(capture_len),
      .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
      .s_axis_tready(s_axis_tready), .m_axis_tdata(m_axis_tdata),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .armed(armed), .busy(busy),
      .done(done), .len_err(len_err)
   );

   always #5 pl_clk = ~pl_clk;

   task automatic chk(input string name, input logic [DW-1:0] act,
                      input logic [DW-1:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   function automatic logic [DW-1:0] mk(input logic [7:0] tag, input int i);
      logic [DW-1:0] r;
      for (int k = 0; k < 8; k++) r[k*32 +: 32] = {tag, 8'(k), 16'(i)};
      return r;
   endfunction

   task automatic tick();
      @(posedge pl_clk);
      #1;
   endtask

   // Model: a valid arm in IDLE opens a new burst of 'len' beats.
   task automatic do_arm(input int len);
      capture_len = (AW+1)'(len);
      arm = 1'b1;
      tick();
      arm = 1'b0;
      if (len >= 1 && len <= DEPTH) begin
         cap_len = len;
         cap_n = 0;
         hs = 0;
         exp_q.delete();
      end
   endtask

   // Rising edge with a junk beat on the same cycle; that beat is not stored.
   task automatic trig();
      trigger = 1'b1;
      s_axis_tvalid = 1'b1;
      s_axis_tdata = mk(8'hEE, 0);
      tick();
      trigger = 1'b0;
      s_axis_tvalid = 1'b0;
   endtask

   // Model: the first cap_len valid beats after the edge, in order.
   task automatic send(input int n, input logic [31:0] pat,
                       input logic [7:0] tag);
      for (int i = 0; i < n; i++) begin
         logic v;
         v = (i < 32) ? pat[i] : 1'b1;
         s_axis_tvalid = v;
         s_axis_tdata = mk(tag, i);
         if (v && cap_n < cap_len) begin
            exp_q.push_back(mk(tag, i));
            cap_n++;
         end
         tick();
      end
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_valid(input int n);
      for (int i = 0; i < n && !m_axis_tvalid; i++) tick();
      chk("wait_valid", m_axis_tvalid, 1);
   endtask

   task automatic wait_done(input int n);
      for (int i = 0; i < n && !done; i++) tick();
      chk("done_set", done, 1);
      chk("handshakes", hs, cap_len);
      chk("model_drained", exp_q.size(), 0);
      chk("idle_after_done", busy, 0);
      chk("valid_after_done", m_axis_tvalid, 0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_tvalid"}, m_axis_tvalid, 0);
      chk({tag, "_tdata"}, m_axis_tdata, 0);
      chk({tag, "_tlast"}, m_axis_tlast, 0);
      chk({tag, "_armed"}, armed, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_len_err"}, len_err, 0);
      chk({tag, "_s_tready"}, s_axis_tready, 1);
   endtask

   initial begin : cmp
      logic prev_stall;
      logic [DW-1:0] prev_d;
      prev_stall = 1'b0;
      prev_d = '0;
      forever begin
         @(negedge pl_clk);
         if (!rst) begin
            prev_stall = 1'b0;
            continue;
         end
         if (prev_stall && !drop_ok) begin
            chk("hold_valid", m_axis_tvalid, 1);
            chk("hold_data", m_axis_tdata, prev_d);
         end
         if (m_axis_tvalid) begin
            if (exp_q.size() == 0) begin
               chk("spurious_valid", m_axis_tvalid, 0);
            end else begin
               chk("rd_data", m_axis_tdata, exp_q[0]);
               chk("rd_last", m_axis_tlast, exp_q.size() == 1);
               if (m_axis_tready) begin
                  void'(exp_q.pop_front());
                  hs++;
               end
            end
         end else begin
            chk("last_idle", m_axis_tlast, 0);
         end
         prev_stall = m_axis_tvalid && !m_axis_tready;
         prev_d = m_axis_tdata;
      end
   end

   initial begin
      #2 rst = 1'b0;
      #1 chk_reset("reset");
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk_reset("post_reset");

      // T1: 4 beats, latency of first tvalid.
      do_arm(4);
      chk("t1_armed", armed, 1);
      trig();
      chk("t1_capture_busy", busy, 1);
      send(4, 32'hF, 8'hA1);
      chk("t1_model_len", exp_q.size(), 4);
      chk("t1_model_first", exp_q[0], mk(8'hA1, 0));
      chk("t1_lat0", m_axis_tvalid, 0);
      tick();
      chk("t1_lat1", m_axis_tvalid, 0);
      tick();
      chk("t1_lat2", m_axis_tvalid, 1);
      wait_done(20);

      // T2: gapped input stored contiguously.
      do_arm(8);
      chk("t2_done_cleared", done, 0);
      trig();
      send(11, 32'h7CD, 8'hA2);
      chk("t2_model_len", exp_q.size(), 8);
      chk("t2_model_b1", exp_q[1], mk(8'hA2, 2));
      chk("t2_model_b7", exp_q[7], mk(8'hA2, 10));
      wait_done(30);

      // T3: readout under back-pressure.
      do_arm(4);
      m_axis_tready = 1'b0;
      trig();
      send(4, 32'hF, 8'hA3);
      wait_valid(10);
      tick();
      tick();
      foreach (exp_q[i]) begin end
      begin
         logic [6:0] pat;
         pat = 7'b1101001;
         for (int i = 0; i < 7; i++) begin
            m_axis_tready = pat[i];
            tick();
         end
      end
      chk("t3_done_in_pattern", done, 1);
      m_axis_tready = 1'b1;
      wait_done(10);

      // T4: trigger already high at arm does not fire.
      trigger = 1'b1;
      do_arm(2);
      s_axis_tvalid = 1'b1;
      s_axis_tdata = mk(8'hBB, 0);
      tick();
      tick();
      tick();
      chk("t4_still_armed", armed, 1);
      chk("t4_busy", busy, 1);
      trigger = 1'b0;
      s_axis_tvalid = 1'b0;
      tick();
      chk("t4_armed_after_fall", armed, 1);
      trig();
      chk("t4_fired", armed, 0);
      send(2, 32'h3, 8'hA4);
      wait_done(20);

      // T5: length errors, ignored arm while armed, full depth.
      do_arm(0);
      chk("t5_err_len0", len_err, 1);
      chk("t5_idle_len0", busy, 0);
      do_arm(DEPTH + 1);
      chk("t5_err_over", len_err, 1);
      chk("t5_idle_over", busy, 0);
      do_arm(DEPTH);
      chk("t5_err_cleared", len_err, 0);
      chk("t5_armed", armed, 1);
      capture_len = '0;
      arm = 1'b1;
      tick();
      arm = 1'b0;
      chk("t5_arm_ignored_err", len_err, 0);
      chk("t5_arm_ignored_state", armed, 1);
      trig();
      send(DEPTH, 32'hFFFF_FFFF, 8'hA5);
      chk("t5_model_len", exp_q.size(), DEPTH);
      wait_done(DEPTH + 50);

      // T6a: abort at the 2nd capture beat.
      do_arm(4);
      trig();
      s_axis_tvalid = 1'b1;
      s_axis_tdata = mk(8'hC1, 0);
      tick();
      s_axis_tdata = mk(8'hC1, 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      s_axis_tvalid = 1'b0;
      chk("t6a_busy", busy, 0);
      chk("t6a_done", done, 0);
      chk("t6a_tvalid", m_axis_tvalid, 0);
      tick();
      tick();
      chk("t6a_tvalid_later", m_axis_tvalid, 0);

      // T6b: abort mid-readout while stalled.
      do_arm(4);
      m_axis_tready = 1'b0;
      trig();
      send(4, 32'hF, 8'hA6);
      wait_valid(10);
      tick();
      drop_ok = 1'b1;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("t6b_tvalid", m_axis_tvalid, 0);
      chk("t6b_done", done, 0);
      chk("t6b_busy", busy, 0);
      exp_q.delete();
      tick();
      tick();
      drop_ok = 1'b0;
      m_axis_tready = 1'b1;

      // T6c: reset at the 2nd capture beat.
      do_arm(4);
      trig();
      s_axis_tvalid = 1'b1;
      s_axis_tdata = mk(8'hC2, 0);
      tick();
      s_axis_tdata = mk(8'hC2, 1);
      rst = 1'b0;
      #1 chk_reset("t6c");
      s_axis_tvalid = 1'b0;
      exp_q.delete();
      tick();
      rst = 1'b1;
      tick();

      // T6d: reset mid-readout while stalled.
      do_arm(4);
      m_axis_tready = 1'b0;
      trig();
      send(4, 32'hF, 8'hA8);
      wait_valid(10);
      tick();
      rst = 1'b0;
      #1 chk_reset("t6d");
      exp_q.delete();
      m_axis_tready = 1'b1;
      tick();
      rst = 1'b1;
      tick();

      // Recovery with a single-beat burst.
      do_arm(1);
      chk("t7_armed", armed, 1);
      trig();
      send(1, 32'h1, 8'hA7);
      wait_done(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
